// File: rtl/add_tree_pkg.sv
// Shared widths, FSM encoding and width-generic saturation helpers for add_tree_acc.
// Latency: none (package only).
// Backpressure: not applicable.
package add_tree_pkg;

  // Width of the scratch vector used by the generic saturation helper.
  // It must be wider than the accumulator of any configuration in use.
  localparam int MAXW = 128;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic            clipped;
    logic [MAXW-1:0] val;
  } sat_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Tree output width: one growth bit per adder level.
  function automatic int tree_width(input int n_in, input int dw);
    return dw + clog2(n_in);
  endfunction

  // Accumulator width: room for ACC_MAX tree results plus the bias.
  function automatic int acc_width(input int n_in, input int dw, input int acc_max);
    return tree_width(n_in, dw) + clog2(acc_max) + 1;
  endfunction

  localparam int TW_DEFAULT = tree_width(32, 32);
  localparam int AW_DEFAULT = acc_width(32, 32, 16);

  // Clip bounds of a dw-bit signed result, sign-extended to MAXW bits.
  function automatic logic signed [MAXW-1:0] sat_min(input int dw);
    logic signed [MAXW-1:0] m;
    m = {MAXW{1'b1}} << (dw - 1);
    return m;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_max(input int dw);
    logic signed [MAXW-1:0] m;
    m = ~({MAXW{1'b1}} << (dw - 1));
    return m;
  endfunction

  localparam logic signed [MAXW-1:0] SAT_MIN_DEFAULT = sat_min(32);
  localparam logic signed [MAXW-1:0] SAT_MAX_DEFAULT = sat_max(32);

  function automatic sat_t saturate(input logic signed [MAXW-1:0] v, input int dw);
    sat_t r;
    r.clipped = 1'b0;
    r.val     = v;
    if (v > sat_max(dw)) begin
      r.val     = sat_max(dw);
      r.clipped = 1'b1;
    end else if (v < sat_min(dw)) begin
      r.val     = sat_min(dw);
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_tree_stage.sv
// One adder-tree level: M signed W-bit inputs -> M/2 exact signed (W+1)-bit pair sums.
// Latency: 1 cycle. Ports: a_vld/a_dat in, y_vld/y_dat out, clear drops the valid.
// Backpressure: none; accepts one beat per cycle unconditionally.
module add_tree_stage #(
  parameter int M = 2,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     a_vld,
  input  logic [M*W-1:0]           a_dat,
  output logic                     y_vld,
  output logic [(M/2)*(W+1)-1:0]   y_dat
);

  logic [(M/2)*(W+1)-1:0] sum;

  // Sign-extend each operand by one bit so the pair sum cannot overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < M / 2; i++) begin
      sum[i*(W+1) +: (W+1)] = {a_dat[(2*i+1)*W-1], a_dat[2*i*W +: W]}
                            + {a_dat[(2*i+2)*W-1], a_dat[(2*i+1)*W +: W]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_vld <= 1'b0;
      y_dat <= '0;
    end else begin
      y_vld <= a_vld & ~clear;
      y_dat <= sum;
    end
  end

endmodule

// File: rtl/add_tree_acc.sv
// N_IN-lane masked signed adder tree, multi-beat accumulator, bias add, optional saturation.
// Latency: L+1 cycles from the input sampling edge to valid_out; ports per lane: valid_in/pxl_in,
// Backpressure: none; one beat per cycle, clear flushes, busy reports work in flight.
module add_tree_acc
  import add_tree_pkg::*;
#(
  parameter int N_IN       = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_MAX    = 16,
  parameter int SAT        = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [clog2(ACC_MAX):0]      cfg_acc_len,
  input  logic [DATA_WIDTH-1:0]        cfg_bias,
  input  logic [N_IN-1:0]              valid_in,
  input  logic [N_IN*DATA_WIDTH-1:0]   pxl_in,
  output logic [DATA_WIDTH-1:0]        pxl_out,
  output logic                         valid_out,
  output logic                         sat_flag,
  output logic                         busy
);

  localparam int L  = clog2(N_IN);
  localparam int CW = clog2(ACC_MAX) + 1;
  localparam int TW = tree_width(N_IN, DATA_WIDTH);
  localparam int AW = acc_width(N_IN, DATA_WIDTH, ACC_MAX);

  // Input register: masked lanes enter as zero so the tree needs no per-lane valids.
  logic [N_IN*DATA_WIDTH-1:0] masked;
  logic [N_IN*DATA_WIDTH-1:0] in_dat;
  logic                       in_vld;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (valid_in[i]) masked[i*DATA_WIDTH +: DATA_WIDTH] = pxl_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_vld <= 1'b0;
      in_dat <= '0;
    end else begin
      in_vld <= (|valid_in) & ~clear;
      in_dat <= masked;
    end
  end

  logic [L:0] pipe_vld;
  assign pipe_vld[0] = in_vld;

  for (genvar g = 1; g <= L; g++) begin : stg
    localparam int M = N_IN >> (g - 1);
    localparam int W = DATA_WIDTH + g - 1;
    logic [(M/2)*(W+1)-1:0] dat;
    logic                   vld;
    if (g == 1) begin : first
      add_tree_stage #(.M(M), .W(W)) u_stage (
        .clk(clk), .reset(reset), .clear(clear),
        .a_vld(in_vld), .a_dat(in_dat), .y_vld(vld), .y_dat(dat)
      );
    end else begin : next
      add_tree_stage #(.M(M), .W(W)) u_stage (
        .clk(clk), .reset(reset), .clear(clear),
        .a_vld(stg[g-1].vld), .a_dat(stg[g-1].dat), .y_vld(vld), .y_dat(dat)
      );
    end
    assign pipe_vld[g] = vld;
  end

  logic [TW-1:0] tree_dat;
  logic          tree_vld;
  assign tree_dat = stg[L].dat;
  assign tree_vld = stg[L].vld;

  acc_state_t            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         len_q;
  logic [DATA_WIDTH-1:0] bias_q;
  logic [AW-1:0]         acc;

  logic [CW-1:0]         eff_len;
  logic [CW-1:0]         cur_len;
  logic [DATA_WIDTH-1:0] cur_bias;
  logic                  last_beat;
  logic [AW-1:0]         tree_x;
  logic [AW-1:0]         bias_x;
  logic [AW-1:0]         total;
  sat_t                  sat_r;
  logic [DATA_WIDTH-1:0] fit_val;
  logic                  fit_flag;

  always_comb begin
    if (cfg_acc_len == '0)                 eff_len = CW'(1);
    else if (cfg_acc_len > CW'(ACC_MAX))   eff_len = CW'(ACC_MAX);
    else                                   eff_len = cfg_acc_len;
    // The first beat of a group takes the live config; later beats use the latched copy.
    cur_len   = (state == IDLE) ? eff_len  : len_q;
    cur_bias  = (state == IDLE) ? cfg_bias : bias_q;
    last_beat = ((cnt + CW'(1)) == cur_len);
    tree_x    = {{(AW-TW){tree_dat[TW-1]}}, tree_dat};
    bias_x    = {{(AW-DATA_WIDTH){cur_bias[DATA_WIDTH-1]}}, cur_bias};
    total     = acc + tree_x + bias_x;
    sat_r     = saturate({{(MAXW-AW){total[AW-1]}}, total}, DATA_WIDTH);
    if (SAT != 0) begin
      fit_val  = sat_r.val[DATA_WIDTH-1:0];
      fit_flag = sat_r.clipped;
    end else begin
      fit_val  = total[DATA_WIDTH-1:0];
      fit_flag = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      bias_q    <= '0;
      acc       <= '0;
      pxl_out   <= '0;
      valid_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
        acc   <= '0;
      end else if (tree_vld) begin
        if (last_beat) begin
          pxl_out   <= fit_val;
          sat_flag  <= fit_flag;
          valid_out <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc   <= acc + tree_x;
          cnt   <= cnt + CW'(1);
          state <= ACC;
          if (state == IDLE) begin
            len_q  <= eff_len;
            bias_q <= cfg_bias;
          end
        end
      end
    end
  end

  assign busy = (|pipe_vld) | (cnt != '0);

endmodule

// File: tb/tb_add_tree_acc.sv
// Scoreboard bench for add_tree_acc: a saturating and a wrapping instance share all stimulus.
// Latency: expected pulses are due L+1 edges after the edge that samples the last beat.
// Backpressure: none exercised; the DUT never stalls.
module tb_add_tree_acc;

  localparam int N   = 32;
  localparam int DW  = 32;
  localparam int LAT = 7;  // drive at negedge n -> sampled at posedge n+1 -> pulse after posedge n+7

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [4:0]        cfg_acc_len;
  logic [DW-1:0]     cfg_bias;
  logic [N-1:0]      valid_in;
  logic [N*DW-1:0]   pxl_in;
  logic [DW-1:0]     p_s, p_w;
  logic              v_s, v_w, f_s, f_w, busy_s, busy_w;

  always #5 clk = ~clk;

  add_tree_acc #(.N_IN(N), .DATA_WIDTH(DW), .ACC_MAX(16), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .cfg_acc_len(cfg_acc_len), .cfg_bias(cfg_bias),
    .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(p_s), .valid_out(v_s), .sat_flag(f_s), .busy(busy_s)
  );

  add_tree_acc #(.N_IN(N), .DATA_WIDTH(DW), .ACC_MAX(16), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .cfg_acc_len(cfg_acc_len), .cfg_bias(cfg_bias),
    .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(p_w), .valid_out(v_w), .sat_flag(f_w), .busy(busy_w)
  );

  typedef struct {
    logic [DW-1:0] val;
    logic          flag;
    int            due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  exp_t es, ew;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (v_s) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_unexpected_pulse: got pxl_out=0x%0h, expected no pulse (cycle %0d)", p_s, cyc);
      end else begin
        es = q_s.pop_front();
        check("sat_pxl_out", 64'(p_s), 64'(es.val));
        check("sat_flag", 64'(f_s), 64'(es.flag));
        check("sat_latency", 64'(cyc), 64'(es.due));
      end
    end
    if (v_w) begin
      if (q_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_unexpected_pulse: got pxl_out=0x%0h, expected no pulse (cycle %0d)", p_w, cyc);
      end else begin
        ew = q_w.pop_front();
        check("wrap_pxl_out", 64'(p_w), 64'(ew.val));
        check("wrap_flag", 64'(f_w), 64'(ew.flag));
        check("wrap_latency", 64'(cyc), 64'(ew.due));
      end
    end
  end

  // Lanes 0-3 get lo, lanes 4.. get hi.
  task automatic beat(input logic [N-1:0] mask, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    @(negedge clk);
    valid_in = mask;
    for (int i = 0; i < N; i++) pxl_in[i*DW +: DW] = (i < 4) ? lo : hi;
    last_cyc = cyc;
  endtask

  task automatic push(input logic [DW-1:0] vs, input logic fs, input logic [DW-1:0] vw, input logic fw);
    exp_t e;
    e.val = vs; e.flag = fs; e.due = last_cyc + LAT;
    q_s.push_back(e);
    e.val = vw; e.flag = fw;
    q_w.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    valid_in = '0;
    while ((busy_s || busy_w) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: busy still high after %0d cycles, expected idle", n);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; cfg_acc_len = 5'd1; cfg_bias = '0;
    valid_in = '0; pxl_in = '0;
    repeat (2) @(negedge clk);
    check("reset_pxl_out", 64'(p_s), 64'd0);
    check("reset_valid_out", 64'(v_s), 64'd0);
    check("reset_sat_flag", 64'(f_s), 64'd0);
    check("reset_busy", 64'(busy_s), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single-beat group, all ones.
    beat('1, 32'd1, 32'd1);
    push(32'd32, 1'b0, 32'd32, 1'b0);
    drain();
    check("hold_pxl_out", 64'(p_s), 64'd32);

    // Lane masking: only lanes 0-3 count.
    beat(32'h0000000F, 32'd10, 32'd1000);
    push(32'd40, 1'b0, 32'd40, 1'b0);
    drain();

    // Two back-to-back 4-beat groups with negative bias: 4*64-5 = 251 each.
    cfg_acc_len = 5'd4; cfg_bias = 32'hFFFF_FFFB;
    for (int b = 0; b < 8; b++) begin
      beat('1, 32'd2, 32'd2);
      if (b == 3 || b == 7) push(32'd251, 1'b0, 32'd251, 1'b0);
    end
    drain();

    // Overflow: saturating instance clips, wrapping instance keeps low bits.
    cfg_acc_len = 5'd1; cfg_bias = '0;
    beat('1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    push(32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFE0, 1'b0);
    beat('1, 32'h8000_0000, 32'h8000_0000);
    push(32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
    drain();

    // Length 0 behaves as length 1.
    cfg_acc_len = 5'd0;
    beat('1, 32'd1, 32'd1);
    push(32'd32, 1'b0, 32'd32, 1'b0);
    drain();

    // Length above ACC_MAX clamps to 16 beats: 16*32 = 512.
    cfg_acc_len = 5'd31;
    for (int b = 0; b < 16; b++) beat('1, 32'd1, 32'd1);
    push(32'd512, 1'b0, 32'd512, 1'b0);
    drain();

    // Clear mid-group, with a beat in the clear cycle; only the fresh group emits.
    cfg_acc_len = 5'd4;
    beat('1, 32'd1, 32'd1);
    beat('1, 32'd1, 32'd1);
    @(negedge clk);
    clear = 1'b1; cfg_acc_len = 5'd1;
    @(negedge clk);
    clear = 1'b0; valid_in = '0;
    beat('1, 32'd3, 32'd3);
    push(32'd96, 1'b0, 32'd96, 1'b0);
    drain();
    check("clear_busy_after", 64'(busy_s), 64'd0);

    // Asynchronous reset mid-group returns everything to zero at once.
    cfg_acc_len = 5'd4;
    beat('1, 32'd1, 32'd1);
    beat('1, 32'd1, 32'd1);
    @(negedge clk);
    valid_in = '0; reset = 1'b0;
    #1;
    check("arst_pxl_out", 64'(p_s), 64'd0);
    check("arst_wrap_pxl_out", 64'(p_w), 64'd0);
    check("arst_valid_out", 64'(v_s), 64'd0);
    check("arst_sat_flag", 64'(f_s), 64'd0);
    check("arst_busy", 64'(busy_s), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; cfg_acc_len = 5'd1;
    beat('1, 32'd1, 32'd1);
    push(32'd32, 1'b0, 32'd32, 1'b0);
    drain();

    check("sat_queue_empty", 64'(q_s.size()), 64'd0);
    check("wrap_queue_empty", 64'(q_w.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
